// File: rtl/coin_acceptor.sv
// Debounces four level-held coin sensors into single-cycle, mutually exclusive coin strobes.
// Optional `define COIN_ACCEPTOR_TOTAL_EN adds a running total_cents output.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned PEND_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        penny_raw,
  input  logic        nickel_raw,
  input  logic        dime_raw,
  input  logic        quarter_raw,
  input  logic        accept_en,
  output logic        penny,
  output logic        nickel,
  output logic        dime,
  output logic        quarter,
  output logic        reject,
`ifdef COIN_ACCEPTOR_TOTAL_EN
  output logic [15:0] total_cents,
`endif
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W:0] CNT_DONE = (CNT_W + 1)'(DEBOUNCE);

  typedef enum logic [1:0] {ARM_WAIT, IDLE, COUNT, HELD} state_t;

  state_t            r_state [4];
  logic [CNT_W-1:0]  r_cnt   [4];
  logic [PEND_W-1:0] r_pend  [4];
  logic [3:0]        r_s;
  logic              r_s_valid;

  logic [3:0]        w_raw;
  logic [3:0]        w_done;
  logic [3:0]        w_inc;
  logic [3:0]        w_pick;
  logic [PEND_W-1:0] w_pend_nxt [4];
  logic              w_reject;
  logic              w_busy_nxt;

  // Channel index order: 0 penny, 1 nickel, 2 dime, 3 quarter.
  assign w_raw = {quarter_raw, dime_raw, nickel_raw, penny_raw};

  always_comb begin
    w_pick = '0;
    if (r_pend[3] != '0)      w_pick = 4'b1000;
    else if (r_pend[2] != '0) w_pick = 4'b0100;
    else if (r_pend[1] != '0) w_pick = 4'b0010;
    else if (r_pend[0] != '0) w_pick = 4'b0001;

    w_done     = '0;
    w_inc      = '0;
    w_reject   = 1'b0;
    w_busy_nxt = 1'b0;
    for (int unsigned c = 0; c < 4; c++) begin
      w_pend_nxt[c] = r_pend[c];
      if (r_s[c]) begin
        if (r_state[c] == IDLE && DEBOUNCE == 1) w_done[c] = 1'b1;
        if (r_state[c] == COUNT && ({1'b0, r_cnt[c]} + 1'b1) == CNT_DONE) w_done[c] = 1'b1;
      end
      // A full counter still accepts when the scheduler drains it on the same edge.
      w_inc[c] = w_done[c] && accept_en && !(r_pend[c] == PEND_MAX && !w_pick[c]);
      if (w_done[c] && !w_inc[c]) w_reject = 1'b1;
      if (w_inc[c] && !w_pick[c])      w_pend_nxt[c] = r_pend[c] + 1'b1;
      else if (!w_inc[c] && w_pick[c]) w_pend_nxt[c] = r_pend[c] - 1'b1;
      if (w_pend_nxt[c] != '0) w_busy_nxt = 1'b1;
    end
  end

`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [15:0] w_val;
  always_comb begin
    w_val = '0;
    case (w_pick)
      4'b1000: w_val = 16'd25;
      4'b0100: w_val = 16'd10;
      4'b0010: w_val = 16'd5;
      4'b0001: w_val = 16'd1;
      default: w_val = '0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s       <= '0;
      r_s_valid <= 1'b0;
      penny     <= 1'b0;
      nickel    <= 1'b0;
      dime      <= 1'b0;
      quarter   <= 1'b0;
      reject    <= 1'b0;
      busy      <= 1'b0;
`ifdef COIN_ACCEPTOR_TOTAL_EN
      total_cents <= '0;
`endif
      for (int unsigned c = 0; c < 4; c++) begin
        r_state[c] <= ARM_WAIT;
        r_cnt[c]   <= '0;
        r_pend[c]  <= '0;
      end
    end else begin
      r_s       <= w_raw;
      r_s_valid <= 1'b1;
      penny     <= w_pick[0];
      nickel    <= w_pick[1];
      dime      <= w_pick[2];
      quarter   <= w_pick[3];
      reject    <= w_reject;
      busy      <= w_busy_nxt;
`ifdef COIN_ACCEPTOR_TOTAL_EN
      total_cents <= total_cents + w_val;
`endif
      for (int unsigned c = 0; c < 4; c++) begin
        r_pend[c] <= w_pend_nxt[c];
        case (r_state[c])
          // r_s_valid keeps the reset-cleared sample from counting as a low level.
          ARM_WAIT: if (r_s_valid && !r_s[c]) r_state[c] <= IDLE;
          IDLE: begin
            if (r_s[c]) begin
              if (DEBOUNCE == 1) begin
                r_state[c] <= HELD;
              end else begin
                r_state[c] <= COUNT;
                r_cnt[c]   <= CNT_W'(1);
              end
            end
          end
          COUNT: begin
            if (!r_s[c])       r_state[c] <= IDLE;
            else if (w_done[c]) r_state[c] <= HELD;
            else               r_cnt[c]   <= r_cnt[c] + 1'b1;
          end
          HELD: if (!r_s[c]) r_state[c] <= IDLE;
          default: r_state[c] <= ARM_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized bench for coin_acceptor: two instances (DEBOUNCE=4 and DEBOUNCE=1 with a
// shallow queue) share stimulus and are compared every cycle against a run-length reference model.
module tb_coin_acceptor;

  localparam int D0  = 4;
  localparam int PW0 = 3;
  localparam int D1  = 1;
  localparam int PW1 = 2;

  logic       clk;
  logic       reset;
  logic [3:0] raw;
  logic       accept_en;

  logic       pn [2];
  logic       ni [2];
  logic       di [2];
  logic       qu [2];
  logic       rj [2];
  logic       bs [2];
`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [15:0] tc [2];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  coin_acceptor #(.DEBOUNCE(D0), .PEND_W(PW0)) u_dut4 (
    .clk(clk), .reset(reset),
    .penny_raw(raw[0]), .nickel_raw(raw[1]), .dime_raw(raw[2]), .quarter_raw(raw[3]),
    .accept_en(accept_en),
    .penny(pn[0]), .nickel(ni[0]), .dime(di[0]), .quarter(qu[0]),
    .reject(rj[0]),
`ifdef COIN_ACCEPTOR_TOTAL_EN
    .total_cents(tc[0]),
`endif
    .busy(bs[0])
  );

  coin_acceptor #(.DEBOUNCE(D1), .PEND_W(PW1)) u_dut1 (
    .clk(clk), .reset(reset),
    .penny_raw(raw[0]), .nickel_raw(raw[1]), .dime_raw(raw[2]), .quarter_raw(raw[3]),
    .accept_en(accept_en),
    .penny(pn[1]), .nickel(ni[1]), .dime(di[1]), .quarter(qu[1]),
    .reject(rj[1]),
`ifdef COIN_ACCEPTOR_TOTAL_EN
    .total_cents(tc[1]),
`endif
    .busy(bs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, per instance and channel.
  bit   m_armed [2][4];
  int   m_run   [2][4];
  int   m_pend  [2][4];
  logic [3:0]  e_strobe [2];
  logic        e_rej    [2];
  logic        e_busy   [2];
  logic [15:0] e_total  [2];
  logic [3:0]  prev_raw;
  bit          prev_valid;

  function automatic int deb(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int pmax(input int i);
    return (i == 0) ? (1 << PW0) - 1 : (1 << PW1) - 1;
  endfunction

  function automatic int cents(input int c);
    case (c)
      0: return 1;
      1: return 5;
      2: return 10;
      default: return 25;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs the DUTs just sampled.
  task automatic model_edge;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) begin
          m_armed[i][c] = 0;
          m_run[i][c]   = 0;
          m_pend[i][c]  = 0;
        end
        e_strobe[i] = '0;
        e_rej[i]    = 1'b0;
        e_busy[i]   = 1'b0;
        e_total[i]  = '0;
      end else begin
        int  pick;
        bit  rej;
        bit  any;
        pick = -1;
        for (int c = 3; c >= 0; c--)
          if (pick < 0 && m_pend[i][c] > 0) pick = c;
        rej = 0;
        for (int c = 0; c < 4; c++) begin
          bit done;
          done = 0;
          if (!m_armed[i][c]) begin
            if (prev_valid && !prev_raw[c]) m_armed[i][c] = 1;
            m_run[i][c] = 0;
          end else if (prev_raw[c]) begin
            if (m_run[i][c] <= deb(i)) m_run[i][c]++;
            if (m_run[i][c] == deb(i)) done = 1;
          end else begin
            m_run[i][c] = 0;
          end
          if (done) begin
            if (!accept_en || (m_pend[i][c] == pmax(i) && pick != c)) rej = 1;
            else m_pend[i][c]++;
          end
        end
        if (pick >= 0) begin
          m_pend[i][pick]--;
          e_strobe[i] = 4'(1 << pick);
          e_total[i]  = 16'((int'(e_total[i]) + cents(pick)) % 65536);
        end else begin
          e_strobe[i] = '0;
        end
        e_rej[i] = rej;
        any = 0;
        for (int c = 0; c < 4; c++) if (m_pend[i][c] != 0) any = 1;
        e_busy[i] = any;
      end
    end
    prev_raw   = raw;
    prev_valid = !reset;
  endtask

  task automatic step(input logic rst, input logic [3:0] r, input logic en);
    @(negedge clk);
    reset     = rst;
    raw       = r;
    accept_en = en;
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    check_eq("d4_strobes", {28'd0, qu[0], di[0], ni[0], pn[0]}, {28'd0, e_strobe[0]});
    check_eq("d4_reject",  {31'd0, rj[0]}, {31'd0, e_rej[0]});
    check_eq("d4_busy",    {31'd0, bs[0]}, {31'd0, e_busy[0]});
    check_eq("d1_strobes", {28'd0, qu[1], di[1], ni[1], pn[1]}, {28'd0, e_strobe[1]});
    check_eq("d1_reject",  {31'd0, rj[1]}, {31'd0, e_rej[1]});
    check_eq("d1_busy",    {31'd0, bs[1]}, {31'd0, e_busy[1]});
`ifdef COIN_ACCEPTOR_TOTAL_EN
    check_eq("d4_total", {16'd0, tc[0]}, {16'd0, e_total[0]});
    check_eq("d1_total", {16'd0, tc[1]}, {16'd0, e_total[1]});
`endif
  endtask

  task automatic hold(input int n, input logic rst, input logic [3:0] r, input logic en);
    for (int k = 0; k < n; k++) step(rst, r, en);
  endtask

  // Each raw channel holds its level for a random run length.
  task automatic random_phase(input int n, input int hi_max, input int lo_max);
    int left [4];
    logic [3:0] lvl;
    lvl = '0;
    for (int c = 0; c < 4; c++) left[c] = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (left[c] == 0) begin
          lvl[c]  = ~lvl[c];
          left[c] = lvl[c] ? int'($urandom_range(1, hi_max)) : int'($urandom_range(1, lo_max));
        end
        left[c]--;
      end
      step(($urandom % 400) == 0, lvl, ($urandom % 12) != 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    raw        = '0;
    accept_en  = 1'b1;
    prev_raw   = '0;
    prev_valid = 0;

    hold(3, 1'b1, 4'b0000, 1'b1);
    hold(3, 1'b0, 4'b0000, 1'b1);
    // Single penny, glitch-length dime, long quarter, simultaneous coins.
    hold(4, 1'b0, 4'b0001, 1'b1);  hold(8, 1'b0, 4'b0000, 1'b1);
    hold(3, 1'b0, 4'b0100, 1'b1);  hold(8, 1'b0, 4'b0000, 1'b1);
    hold(10, 1'b0, 4'b1000, 1'b1); hold(8, 1'b0, 4'b0000, 1'b1);
    hold(4, 1'b0, 4'b1111, 1'b1);  hold(10, 1'b0, 4'b0000, 1'b1);
    // Disabled acceptance.
    hold(4, 1'b0, 4'b0010, 1'b0);  hold(6, 1'b0, 4'b0000, 1'b1);
    // Jammed dime through reset release.
    hold(3, 1'b1, 4'b0100, 1'b1);  hold(5, 1'b0, 4'b0100, 1'b1);
    hold(1, 1'b0, 4'b0000, 1'b1);  hold(4, 1'b0, 4'b0100, 1'b1);
    hold(8, 1'b0, 4'b0000, 1'b1);
    // Long and short runs; the short runs overflow the shallow queue.
    random_phase(3000, 7, 3);
    random_phase(2000, 2, 1);
    random_phase(1000, 6, 2);
    hold(20, 1'b0, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
